// File: rtl/vga_fb_arbiter_if.sv
// Framebuffer arbiter bus: pixel scanout, host write port and RAM port.
// Signals are a plain bundle; timing is owned by vga_fb_arbiter.
// slave modport = the arbiter, master modport = driver/host/RAM side.
interface vga_fb_arbiter_if #(
    parameter int ADDR_W = 17
);
    // scanout side
    logic              frame_start;
    logic              pix_req;
    logic [2:0]        pixel_data;
    logic              underflow;
    // host write side
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [11:0]       wr_data;
    logic              wr_ack;
    // single-port RAM side
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [11:0]       mem_wdata;
    logic [11:0]       mem_rdata;

    modport slave (
        input  frame_start, pix_req, wr_req, wr_addr, wr_data, mem_rdata,
        output pixel_data, underflow, wr_ack, mem_addr, mem_we, mem_wdata
    );

    modport master (
        output frame_start, pix_req, wr_req, wr_addr, wr_data, mem_rdata,
        input  pixel_data, underflow, wr_ack, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Shares a single-port framebuffer RAM between VGA scanout (priority) and a host writer.
// Latency: pix_req -> pixel_data 1 cycle; grant -> mem_* / wr_ack 1 cycle; read data 2 cycles after grant.
// Backpressure: host wr_req waits while a display prefetch is eligible; empty buffer on pix_req -> sticky underflow.
// Ports: vga_clk, rst_n (async, active-low); bus (slave): frame_start, pix_req, pixel_data, underflow,
//        wr_req/wr_addr/wr_data/wr_ack host port, mem_addr/mem_we/mem_wdata/mem_rdata RAM port.
module vga_fb_arbiter #(
    parameter int ADDR_W      = 17,
    parameter int FRAME_WORDS = 120000
) (
    input  logic            vga_clk,
    input  logic            rst_n,
    vga_fb_arbiter_if.slave bus
);

    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(FRAME_WORDS - 1);

    typedef enum logic [1:0] {
        GNT_IDLE,
        GNT_READ,
        GNT_WRITE
    } gnt_t;

    // memory port registers
    logic [ADDR_W-1:0] mem_addr_q;
    logic              mem_we_q;
    logic [11:0]       mem_wdata_q;
    logic              wr_ack_q;

    // scanout state
    logic [ADDR_W-1:0] rd_ptr;
    logic              rd_q1;        // read granted last cycle (address on the RAM now)
    logic              rd_q2;        // read whose data is on mem_rdata now
    logic              rd_q2_drop;   // that read belongs to a flushed frame
    logic [11:0]       fifo_w0;      // head
    logic [11:0]       fifo_w1;
    logic [1:0]        fifo_cnt;
    logic [11:0]       unp_word;
    logic [1:0]        unp_idx;
    logic              unp_vld;
    logic [2:0]        pixel_q;
    logic              underflow_q;

    // combinational
    gnt_t              gnt;
    logic [1:0]        inflight;
    logic              fetch_ok;
    logic              rd_ret;
    logic              cur_vld;
    logic [11:0]       cur_word;
    logic [1:0]        cur_idx;
    logic [2:0]        cur_pix;
    logic              consume;
    logic              pop;

    assign inflight = {1'b0, rd_q1} + {1'b0, rd_q2};
    // Reserve a FIFO slot for every outstanding read so a return can never overflow.
    assign fetch_ok = ({1'b0, fifo_cnt} + {1'b0, inflight}) < 3'd2;

    // Reads are held off on frame_start so nothing is fetched from the old rd_ptr.
    always_comb begin
        gnt = GNT_IDLE;
        if (!bus.frame_start && fetch_ok) begin
            gnt = GNT_READ;
        end else if (bus.wr_req) begin
            gnt = GNT_WRITE;
        end
    end

    assign rd_ret = rd_q2 && !rd_q2_drop && !bus.frame_start;

    // The unpack stage sees the FIFO head directly when it is empty, so a word
    // that just landed can feed a pixel in the same cycle it is popped.
    assign cur_vld  = unp_vld || (fifo_cnt != 2'd0);
    assign cur_word = unp_vld ? unp_word : fifo_w0;
    assign cur_idx  = unp_vld ? unp_idx : 2'd0;
    assign consume  = bus.pix_req && !bus.frame_start && cur_vld;
    assign pop      = !bus.frame_start && (fifo_cnt != 2'd0) &&
                      (!unp_vld || (consume && unp_idx == 2'd3));

    always_comb begin
        cur_pix = cur_word[11:9];
        case (cur_idx)
            2'd0:    cur_pix = cur_word[11:9];
            2'd1:    cur_pix = cur_word[8:6];
            2'd2:    cur_pix = cur_word[5:3];
            default: cur_pix = cur_word[2:0];
        endcase
    end

    // RAM port and host acknowledge
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            wr_ack_q    <= 1'b0;
        end else begin
            wr_ack_q <= (gnt == GNT_WRITE);
            case (gnt)
                GNT_READ: begin
                    mem_addr_q <= rd_ptr;
                    mem_we_q   <= 1'b0;
                end
                GNT_WRITE: begin
                    mem_addr_q  <= bus.wr_addr;
                    mem_wdata_q <= bus.wr_data;
                    mem_we_q    <= 1'b1;
                end
                default: mem_we_q <= 1'b0;
            endcase
        end
    end

    // Read pointer and in-flight tracking. Reads cannot be granted on frame_start,
    // so only the read already at the address stage needs a discard mark.
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr     <= '0;
            rd_q1      <= 1'b0;
            rd_q2      <= 1'b0;
            rd_q2_drop <= 1'b0;
        end else begin
            rd_q1      <= (gnt == GNT_READ);
            rd_q2      <= rd_q1;
            rd_q2_drop <= rd_q1 && bus.frame_start;
            if (bus.frame_start) begin
                rd_ptr <= '0;
            end else if (gnt == GNT_READ) begin
                rd_ptr <= (rd_ptr == LAST_WORD) ? '0 : rd_ptr + ADDR_W'(1);
            end
        end
    end

    // Two-entry word FIFO, head in fifo_w0
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_w0  <= '0;
            fifo_w1  <= '0;
            fifo_cnt <= 2'd0;
        end else if (bus.frame_start) begin
            fifo_cnt <= 2'd0;
        end else begin
            case ({rd_ret, pop})
                2'b10: begin
                    if (fifo_cnt == 2'd0) fifo_w0 <= bus.mem_rdata;
                    else                  fifo_w1 <= bus.mem_rdata;
                    fifo_cnt <= fifo_cnt + 2'd1;
                end
                2'b01: begin
                    fifo_w0  <= fifo_w1;
                    fifo_cnt <= fifo_cnt - 2'd1;
                end
                2'b11: begin
                    if (fifo_cnt == 2'd1) begin
                        fifo_w0 <= bus.mem_rdata;
                    end else begin
                        fifo_w0 <= fifo_w1;
                        fifo_w1 <= bus.mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    // Unpack register
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            unp_word <= '0;
            unp_idx  <= 2'd0;
            unp_vld  <= 1'b0;
        end else if (bus.frame_start) begin
            unp_idx <= 2'd0;
            unp_vld <= 1'b0;
        end else if (pop) begin
            unp_word <= fifo_w0;
            unp_vld  <= 1'b1;
            // popped into an empty register and used immediately: pixel 0 is gone
            unp_idx  <= (!unp_vld && consume) ? 2'd1 : 2'd0;
        end else if (consume) begin
            unp_idx <= unp_idx + 2'd1;
            if (unp_idx == 2'd3) unp_vld <= 1'b0;
        end
    end

    // Pixel output and sticky underflow
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_q     <= 3'd0;
            underflow_q <= 1'b0;
        end else if (bus.frame_start) begin
            underflow_q <= 1'b0;
        end else if (bus.pix_req) begin
            if (cur_vld) begin
                pixel_q <= cur_pix;
            end else begin
                pixel_q     <= 3'd0;
                underflow_q <= 1'b1;
            end
        end
    end

    assign bus.pixel_data = pixel_q;
    assign bus.underflow  = underflow_q;
    assign bus.wr_ack     = wr_ack_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Testbench for vga_fb_arbiter: scoreboard of pixels and writes against a frame-level model.
// Small FRAME_WORDS so the scanout address wraps many times; host writes go off-screen.
// RAM is a synchronous single-port model owned by the bench.
module tb_vga_fb_arbiter;

    localparam int AW    = 17;
    localparam int FW    = 16;
    localparam int RAM_N = FW + 64;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [11:0]   d;
    } wjob_t;

    logic vga_clk;
    logic rst_n;

    vga_fb_arbiter_if #(.ADDR_W(AW)) bus ();

    vga_fb_arbiter #(.ADDR_W(AW), .FRAME_WORDS(FW)) dut (
        .vga_clk (vga_clk),
        .rst_n   (rst_n),
        .bus     (bus.slave)
    );

    initial begin
        vga_clk = 1'b0;
        forever #5 vga_clk = ~vga_clk;
    end

    // bench state
    int          n_chk = 0;
    int          n_pass = 0;
    logic [11:0] ram  [RAM_N];
    logic [11:0] gold [RAM_N];
    bit          gold_set [RAM_N];
    logic [3:0]  exp_pix [$];        // {underflow, pixel}
    wjob_t       exp_wr [$];
    wjob_t       wr_jobs [$];
    logic [2:0]  hold_pix = 3'd0;
    bit          mon_en = 1'b0;
    logic        pr_q = 1'b0;
    int          ack_limit = 1;
    int          wr_lat = 0;

    // frame model: pixel k of the frame is pixel k%4 of word k/4 (mod frame size);
    // data is available from the 4th cycle after frame_start
    int          m_k = 0;
    int          m_since = 1000;
    bit          m_uf = 1'b0;
    logic [2:0]  m_last = 3'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [2:0] model_pixel(input int k);
        logic [11:0] w;
        w = gold[(k / 4) % FW];
        case (k % 4)
            0:       return w[11:9];
            1:       return w[8:6];
            2:       return w[5:3];
            default: return w[2:0];
        endcase
    endfunction

    // Drives one cycle of scanout stimulus (called at posedge+1) and records the expectation.
    task automatic drive_cycle(input bit fs, input bit pr);
        logic [2:0] p;
        bus.frame_start = fs;
        bus.pix_req     = pr;
        if (fs) begin
            m_k = 0; m_since = 0; m_uf = 1'b0;
            if (pr) exp_pix.push_back({1'b0, m_last});
        end else begin
            if (m_since < 1000) m_since++;
            if (pr) begin
                if (m_since >= 4) begin
                    p = model_pixel(m_k);
                    m_k++;
                end else begin
                    p = 3'd0;
                    m_uf = 1'b1;
                end
                m_last = p;
                exp_pix.push_back({m_uf, p});
            end
        end
        @(posedge vga_clk); #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pixel_data"}, 32'(bus.pixel_data), 32'd0);
        check({tag, "_underflow"},  32'(bus.underflow),  32'd0);
        check({tag, "_wr_ack"},     32'(bus.wr_ack),     32'd0);
        check({tag, "_mem_we"},     32'(bus.mem_we),     32'd0);
        check({tag, "_mem_addr"},   32'(bus.mem_addr),   32'd0);
        check({tag, "_mem_wdata"},  32'(bus.mem_wdata),  32'd0);
    endtask

    // synchronous single-port RAM: address in t+1, data visible in t+2
    always @(posedge vga_clk) begin
        if (bus.mem_we && int'(bus.mem_addr) < RAM_N) ram[int'(bus.mem_addr)] <= bus.mem_wdata;
        bus.mem_rdata <= (int'(bus.mem_addr) < RAM_N) ? ram[int'(bus.mem_addr)] : 12'h000;
    end

    always @(posedge vga_clk) pr_q <= bus.pix_req & rst_n;

    // host writer: takes jobs from wr_jobs, holds wr_req until wr_ack, measures latency
    initial begin
        wjob_t j;
        bus.wr_req  = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        forever begin
            @(posedge vga_clk); #1;
            if (bus.wr_req) begin
                if (bus.wr_ack) begin
                    n_chk++;
                    if (wr_lat <= ack_limit) n_pass++;
                    else $display("FAIL wr_ack_latency: took %0d cycles, limit %0d (t=%0t)", wr_lat, ack_limit, $time);
                    bus.wr_req = 1'b0;
                end else begin
                    wr_lat++;
                    if (wr_lat > 20) begin
                        n_chk++;
                        $display("FAIL wr_ack_timeout: no ack after %0d cycles, required within %0d", wr_lat, ack_limit);
                        bus.wr_req = 1'b0;
                        if (exp_wr.size() != 0) exp_wr.delete(exp_wr.size() - 1);
                    end
                end
            end
            if (!bus.wr_req && wr_jobs.size() != 0) begin
                j = wr_jobs.pop_front();
                bus.wr_req  = 1'b1;
                bus.wr_addr = j.a;
                bus.wr_data = j.d;
                wr_lat      = 1;
                exp_wr.push_back(j);
                gold[int'(j.a)]     = j.d;
                gold_set[int'(j.a)] = 1'b1;
            end
        end
    end

    // monitor: compares pixel output the cycle after each request, and RAM port on wr_ack
    initial begin
        logic [3:0] e;
        wjob_t      w;
        forever begin
            @(negedge vga_clk);
            if (mon_en) begin
                if (pr_q) begin
                    if (exp_pix.size() == 0) begin
                        check("pix_scoreboard_empty", 32'd1, 32'd0);
                    end else begin
                        e = exp_pix.pop_front();
                        check("pixel_data", 32'(bus.pixel_data), 32'(e[2:0]));
                        check("underflow",  32'(bus.underflow),  32'(e[3]));
                        hold_pix = e[2:0];
                    end
                end else begin
                    check("pixel_hold", 32'(bus.pixel_data), 32'(hold_pix));
                end
            end
            if (rst_n && bus.wr_ack) begin
                if (exp_wr.size() == 0) begin
                    check("wr_scoreboard_empty", 32'd1, 32'd0);
                end else begin
                    w = exp_wr.pop_front();
                    check("mem_we_on_ack",    32'(bus.mem_we),    32'd1);
                    check("mem_addr_on_ack",  32'(bus.mem_addr),  32'(w.a));
                    check("mem_wdata_on_ack", 32'(bus.mem_wdata), 32'(w.d));
                end
            end
        end
    end

    initial begin
        logic [11:0] init_w [4];
        wjob_t       j;
        int          n;
        bit          fs;
        bit          pr;
        init_w = '{12'o0123, 12'o4567, 12'o7654, 12'o3210};

        rst_n           = 1'b0;
        bus.frame_start = 1'b0;
        bus.pix_req     = 1'b0;
        repeat (3) @(posedge vga_clk);
        #1;
        check_reset_outputs("por");
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // let the prefetch buffer fill, then preload the frame through the host port
        repeat (12) drive_cycle(1'b0, 1'b0);
        ack_limit = 1;
        for (int i = 0; i < FW; i++) begin
            j.a = AW'(i);
            j.d = (i < 4) ? init_w[i] : 12'($urandom_range(1, 4095));
            wr_jobs.push_back(j);
        end
        n = 0;
        while ((wr_jobs.size() != 0 || bus.wr_req) && n < 200) begin
            drive_cycle(1'b0, 1'b0);
            n++;
        end
        if (n >= 200) check("preload_timeout", 32'd1, 32'd0);
        repeat (2) drive_cycle(1'b0, 1'b0);

        // scanout of words 0..3
        drive_cycle(1'b1, 1'b0);
        repeat (7) drive_cycle(1'b0, 1'b0);
        repeat (16) drive_cycle(1'b0, 1'b1);
        repeat (3) drive_cycle(1'b0, 1'b0);

        // underflow right after frame_start, then a few real pixels
        drive_cycle(1'b1, 1'b0);
        drive_cycle(1'b0, 1'b1);
        repeat (3) drive_cycle(1'b0, 1'b0);
        repeat (3) drive_cycle(1'b0, 1'b1);
        repeat (2) drive_cycle(1'b0, 1'b0);

        // asynchronous reset in mid-cycle
        #2;
        rst_n  = 1'b0;
        mon_en = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        exp_pix.delete();
        hold_pix = 3'd0;
        m_last   = 3'd0;
        repeat (3) @(posedge vga_clk);
        #1;
        rst_n       = 1'b1;
        bus.pix_req = 1'b1;          // buffer must be empty right after release
        exp_pix.push_back({1'b1, 3'd0});
        mon_en      = 1'b1;
        @(posedge vga_clk); #1;
        drive_cycle(1'b1, 1'b1);     // frame_start wins over pix_req and clears underflow

        // full line with a burst of 50 host writes in the middle
        repeat (7) drive_cycle(1'b0, 1'b0);
        ack_limit = 2;
        for (int i = 0; i < 800; i++) begin
            if (i == 40) begin
                for (int w = 0; w < 50; w++) begin
                    j.a = AW'(FW + (w % 64));
                    j.d = 12'($urandom_range(0, 4095));
                    wr_jobs.push_back(j);
                end
            end
            drive_cycle(1'b0, 1'b1);
        end
        repeat (3) drive_cycle(1'b0, 1'b0);

        // random traffic with mid-line frame flushes
        ack_limit = 4;
        for (int i = 0; i < 2000; i++) begin
            fs = ($urandom_range(0, 149) == 0);
            pr = ($urandom_range(0, 3) != 0);
            if (!bus.wr_req && wr_jobs.size() == 0 && $urandom_range(0, 7) == 0) begin
                j.a = AW'(FW + $urandom_range(0, 63));
                j.d = 12'($urandom_range(0, 4095));
                wr_jobs.push_back(j);
            end
            drive_cycle(fs, pr);
        end

        n = 0;
        while ((wr_jobs.size() != 0 || bus.wr_req) && n < 200) begin
            drive_cycle(1'b0, 1'b0);
            n++;
        end
        if (n >= 200) check("final_write_timeout", 32'd1, 32'd0);
        repeat (4) drive_cycle(1'b0, 1'b0);

        for (int a = 0; a < RAM_N; a++) begin
            if (gold_set[a]) check($sformatf("ram[%0d]", a), 32'(ram[a]), 32'(gold[a]));
        end
        check("pix_scoreboard_left", 32'(exp_pix.size()), 32'd0);
        check("wr_scoreboard_left",  32'(exp_wr.size()),  32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
